tpg_checker: RTL
================

TPG_CHECKER -- requirements
Module: tpg_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, stream data width (minimum 24).
REQ-002 SHALL have parameter HVALID, default 640, pixels per line.
REQ-003 SHALL have parameter VVALID, default 480, lines per frame.
REQ-004 SHALL have port axis_clk, input, 1, the single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have AXI-stream sink ports: in_axis_tvalid input 1, in_axis_tready output 1, in_axis_tuser input 1 (start of frame), in_axis_tlast input 1 (end of line), in_axis_tdata input WIDTH.
REQ-007 SHALL have port clr_i, input, 1, synchronous clear of counters and sticky flags.
REQ-008 SHALL have port locked_o, output, 1, set after one error-free frame.
REQ-009 SHALL have port frame_count_o, output, 16, count of completed frames.
REQ-010 SHALL have port err_count_o, output, 16, count of error beats.
REQ-011 SHALL have port err_flags_o, output, 4, sticky flags {data, sof, eol_early, eol_late}, bit 3 down to 0.
REQ-012 SHALL have port state_o, output, 2, current FSM state encoding.

Function
REQ-013 SHALL treat a beat as accepted only when in_axis_tvalid and in_axis_tready are both 1 in the same cycle.
REQ-014 SHALL, for an accepted beat at pixel position (h, v), expect tdata[23:0] = {2'b11, v[9:0], 2'b11, h[9:0]}; bits above 23 are ignored.
REQ-015 SHALL use FSM states HUNT=0, RUN=1, SOF_WAIT=2.
REQ-016 SHALL, in HUNT, discard beats until one with tuser=1, check that beat as (0,0), then enter RUN with h=1, v=0.
REQ-017 SHALL, in RUN, raise a data error on any accepted beat whose tdata mismatches the expected value, and still advance h.
REQ-018 SHALL raise eol_early on tlast=1 with h<HVALID-1, then end the line: h=0, v=v+1.
REQ-019 SHALL raise eol_late on tlast=0 with h==HVALID-1, then go to HUNT.
REQ-020 SHALL raise a sof error on tuser=1 at any position other than (0,0), then restart at (0,0), counting that beat as pixel 0.
REQ-021 SHALL, on a correct tlast with v==VVALID-1, increment frame_count_o (wrap at 0xFFFF) and enter SOF_WAIT.
REQ-022 SHALL, in SOF_WAIT, treat a beat with tuser=1 as pixel (0,0) and enter RUN; tuser=0 raises a sof error and enters HUNT.
REQ-023 SHALL count at most one error per beat in err_count_o, saturating at 0xFFFF; all applicable sticky flags set in the same cycle.
REQ-024 SHALL set locked_o on completion of a frame with no error since the preceding SOF, and clear it on any error or on entering HUNT.
REQ-025 SHALL make clr_i override same-cycle events: counters and flags go to 0, the FSM is unaffected, and an error in that cycle is dropped.
REQ-026 SHALL register all outputs, with one-cycle latency from the accepted beat to counter and flag updates.

Reset
REQ-027 SHALL, while rst_n=0, drive in_axis_tready=0, locked_o=0, frame_count_o=0, err_count_o=0, err_flags_o=0, state_o=HUNT, h=0, v=0.
REQ-028 SHALL deassert reset with no spurious beat acceptance; a reset asserted mid-frame returns to HUNT.

Configuration
REQ-029 SHALL, with TPG_CHECKER_BP_EN defined, drive in_axis_tready=0 when lfsr[1:0]==2'b00 and 1 otherwise; the 16-bit LFSR uses polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, and advances every cycle.
REQ-030 SHALL, without TPG_CHECKER_BP_EN, drive in_axis_tready=1 in every cycle out of reset, with no LFSR logic present.

Structure
REQ-031 SHALL place state encodings, pattern marker 2'b11, and the LFSR seed and taps in shared package tpg_pkg.
REQ-032 SHALL instantiate the backpressure generator as sub-module tpg_lfsr16, present only when TPG_CHECKER_BP_EN is defined.

Verification
REQ-033 SHALL cover two clean 640x480 frames: frame_count_o=2, err_count_o=0, locked_o=1.
REQ-034 SHALL cover corrupting tdata at (5,3) to 0: err_flags_o=4'b1000, err_count_o=1, locked_o=0.
REQ-035 SHALL cover tlast at h=100 on line 7: eol_early set, and the next beat is expected as (0,8).
REQ-036 SHALL cover tlast missing at h=639: eol_late set, state_o=HUNT, and the next tuser relocks with no further errors.
REQ-037 SHALL cover stray tuser at (20,10): sof set, err_count_o=1, and that beat is checked as (0,0).
REQ-038 SHALL cover asserting clr_i together with a data error: all counters and flags 0 the next cycle; with TPG_CHECKER_BP_EN, a clean frame still gives err_count_o=0.

Source files
------------

// File: rtl/tpg_pkg.sv
// tpg_pkg: shared definitions for the test-pattern checker.
//   - FSM state encodings
//   - pattern marker bits inserted above each 10-bit coordinate
//   - seed and Galois tap mask of the 16-bit backpressure LFSR
//   - error flag bit positions and the expected-pixel helper
package tpg_pkg;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_SOF_WAIT = 2'd2
  } tpg_state_t;

  localparam logic [1:0]  PAT_MARK  = 2'b11;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int ERR_DATA  = 3;
  localparam int ERR_SOF   = 2;
  localparam int ERR_EARLY = 1;
  localparam int ERR_LATE  = 0;

  function automatic logic [23:0] tpg_pixel(input logic [9:0] h, input logic [9:0] v);
    return {PAT_MARK, v, PAT_MARK, h};
  endfunction

endpackage

// File: rtl/tpg_lfsr16.sv
// tpg_lfsr16: pseudo-random backpressure source.
//   axis_clk : clock
//   rst_n    : asynchronous active-low reset (loads the seed)
//   ready    : lookahead ready, i.e. the value the next LFSR state implies;
//              the parent registers it so its output tracks lfsr[1:0] != 0
module tpg_lfsr16
  import tpg_pkg::*;
(
  input  logic axis_clk,
  input  logic rst_n,
  output logic ready
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    ready     = (lfsr_next[1:0] != 2'b00);
  end

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next;
  end

endmodule

// File: rtl/tpg_checker.sv
// tpg_checker: checks an AXI-stream video test pattern whose pixel at (h, v)
// carries {2'b11, v[9:0], 2'b11, h[9:0]} in tdata[23:0].
//   axis_clk, rst_n         : clock, asynchronous active-low reset
//   in_axis_*               : stream sink (tuser = start of frame, tlast = end of line)
//   clr_i                   : synchronous clear of counters and sticky flags
//   locked_o                : set after an error-free frame
//   frame_count_o           : completed frames (wraps)
//   err_count_o             : beats with at least one error (saturates)
//   err_flags_o             : sticky {data, sof, eol_early, eol_late}
//   state_o                 : FSM state
// Build option: define TPG_CHECKER_BP_EN to drive tready from an LFSR
// (tpg_lfsr16); otherwise tready is held high out of reset.
//
// state    | meaning
// HUNT     | discard beats until a tuser beat arrives
// RUN      | checking pixels of a frame
// SOF_WAIT | frame done, next beat must carry tuser
module tpg_checker
  import tpg_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HVALID = 640,
  parameter int VVALID = 480
) (
  input  logic             axis_clk,
  input  logic             rst_n,
  input  logic             in_axis_tvalid,
  output logic             in_axis_tready,
  input  logic             in_axis_tuser,
  input  logic             in_axis_tlast,
  input  logic [WIDTH-1:0] in_axis_tdata,
  input  logic             clr_i,
  output logic             locked_o,
  output logic [15:0]      frame_count_o,
  output logic [15:0]      err_count_o,
  output logic [3:0]       err_flags_o,
  output logic [1:0]       state_o
);

  localparam logic [15:0] H_LAST = 16'(HVALID - 1);
  localparam logic [15:0] V_LAST = 16'(VVALID - 1);

  tpg_state_t  state, state_nx;
  logic [15:0] h, v, h_nx, v_nx;
  logic        frame_ok;
  logic        beat, check, new_frame, frame_done, err_hit, bp_ready;
  logic [23:0] exp_pix;
  logic [3:0]  err_now;

`ifdef TPG_CHECKER_BP_EN
  tpg_lfsr16 u_lfsr (
    .axis_clk (axis_clk),
    .rst_n    (rst_n),
    .ready    (bp_ready)
  );
`else
  assign bp_ready = 1'b1;
`endif

  generate
    if (WIDTH > 24) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^in_axis_tdata[WIDTH-1:24];
    end
  endgenerate

  assign beat    = in_axis_tvalid & in_axis_tready;
  assign state_o = state;

  always_comb begin
    state_nx   = state;
    h_nx       = h;
    v_nx       = v;
    check      = 1'b0;
    new_frame  = 1'b0;
    frame_done = 1'b0;
    err_now    = 4'b0000;
    exp_pix    = tpg_pixel(h[9:0], v[9:0]);
    if (beat) begin
      // any tuser beat that is accepted restarts the frame at pixel (0,0)
      if (in_axis_tuser && state != ST_HUNT && state != ST_SOF_WAIT) begin
        err_now[ERR_SOF] = (h != 16'd0) || (v != 16'd0);
      end
      unique case (state)
        ST_HUNT, ST_SOF_WAIT: begin
          if (in_axis_tuser) begin
            check     = 1'b1;
            new_frame = 1'b1;
            exp_pix   = tpg_pixel(10'd0, 10'd0);
            state_nx  = ST_RUN;
            h_nx      = 16'd1;
            v_nx      = 16'd0;
          end else if (state == ST_SOF_WAIT) begin
            err_now[ERR_SOF] = 1'b1;
            state_nx         = ST_HUNT;
          end
        end
        ST_RUN: begin
          check = 1'b1;
          if (in_axis_tuser) begin
            new_frame = 1'b1;
            exp_pix   = tpg_pixel(10'd0, 10'd0);
            h_nx      = 16'd1;
            v_nx      = 16'd0;
          end else if (in_axis_tlast) begin
            h_nx = 16'd0;
            v_nx = v + 16'd1;
            if (h != H_LAST) begin
              err_now[ERR_EARLY] = 1'b1;
              // a short last line leaves no valid line to move on to
              if (v == V_LAST) state_nx = ST_HUNT;
            end else if (v == V_LAST) begin
              frame_done = 1'b1;
              state_nx   = ST_SOF_WAIT;
              v_nx       = 16'd0;
            end
          end else if (h == H_LAST) begin
            err_now[ERR_LATE] = 1'b1;
            state_nx          = ST_HUNT;
          end else begin
            h_nx = h + 16'd1;
          end
        end
        default: state_nx = ST_HUNT;
      endcase
      err_now[ERR_DATA] = check && (in_axis_tdata[23:0] != exp_pix);
    end
    if (state_nx == ST_HUNT) begin
      h_nx = 16'd0;
      v_nx = 16'd0;
    end
  end

  // clear drops the beat's error entirely, including its effect on lock
  assign err_hit = (err_now != 4'b0000) && !clr_i;

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_HUNT;
      h              <= 16'd0;
      v              <= 16'd0;
      frame_ok       <= 1'b0;
      in_axis_tready <= 1'b0;
      locked_o       <= 1'b0;
      frame_count_o  <= 16'd0;
      err_count_o    <= 16'd0;
      err_flags_o    <= 4'b0000;
    end else begin
      in_axis_tready <= bp_ready;
      state          <= state_nx;
      h              <= h_nx;
      v              <= v_nx;

      if (clr_i) begin
        frame_count_o <= 16'd0;
        err_count_o   <= 16'd0;
        err_flags_o   <= 4'b0000;
      end else begin
        if (frame_done) frame_count_o <= frame_count_o + 16'd1;
        if (err_hit) begin
          if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
          err_flags_o <= err_flags_o | err_now;
        end
      end

      if (new_frame)    frame_ok <= !err_hit;
      else if (err_hit) frame_ok <= 1'b0;

      if (err_hit || state_nx == ST_HUNT)  locked_o <= 1'b0;
      else if (frame_done && frame_ok)     locked_o <= 1'b1;
    end
  end

endmodule
